ifu_axi_read_bridge: RTL and testbench
======================================

Name: ifu_axi_read_bridge

Overview:
- Single-outstanding read bridge between the fetch stage's simple request/data handshake (rx_r_* / rx_data_*) and an AXI4 read channel (AR/R) toward instruction memory.
- Accepts one fetch address, issues one single-beat AXI read, buffers the 64-bit beat and holds it until the fetch stage consumes it.
- Sits directly upstream of the IF stage, between it and the memory/crossbar.

Parameters:
- ADDR_W, 64, address width on both sides.
- DATA_W, 64, data width; one beat per transaction.
- ID, 4'd0, constant ARID driven on every request.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_r_valid_i  in  1  fetch request valid.
- rx_r_ready_o  out  1  bridge can accept a request.
- rx_r_addr_i  in  64  fetch byte address.
- rx_r_size_i  in  8  byte-enable mask within the 8-byte word (8'h0F = 4 bytes).
- rx_data_read_o  out  64  returned aligned 64-bit word.
- rx_data_valid  out  1  returned word valid.
- rx_data_ready  in  1  fetch stage accepts the word.
- rx_resp_err  out  1  qualifies rx_data_valid; the beat returned RRESP != OKAY.
- araddr  out  64  AXI read address, 8-byte aligned.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- arid  out  4  = ID.
- arlen  out  8  constant 0.
- arsize  out  3  derived from rx_r_size_i.
- arburst  out  2  constant 2'b01 (INCR).
- rdata  in  64  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- Reset values:
  - state = IDLE.
  - rx_r_ready_o = 1; rx_data_valid = 0; rx_resp_err = 0; rx_data_read_o = 0.
  - arvalid = 0; araddr = 0; arsize = 0; rready = 0.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - rx_r_ready_o = 1; all other handshake outputs are 0.
  - On rx_r_valid_i: latch the address with araddr = {addr[63:3], 3'b000}.
  - Latch arsize from the popcount of rx_r_size_i: 1→0, 2→1, 4→2, 8→3; any other value → 3.
  - Transition to ADDR. arvalid is high from the next cycle.
- ADDR:
  - arvalid = 1, with araddr and arsize stable until arready.
  - On arvalid && arready → DATA.
  - rx_r_ready_o = 0 from here until return to IDLE.
- DATA:
  - rready = 1.
  - On rvalid: latch rdata into rx_data_read_o and latch (rresp != 2'b00) into rx_resp_err, then → HOLD.
  - rlast is expected high; if it is low the beat is still taken and the transaction still ends (single-beat protocol).
- HOLD:
  - rx_data_valid = 1; rx_data_read_o and rx_resp_err stay stable.
  - On rx_data_ready → IDLE, and rx_data_valid drops next cycle.
  - rx_r_ready_o is not asserted in the same cycle. This gives a one-cycle gap, and the fetch stage tolerates it.
- Latency, zero-wait memory (arready = rvalid = 1):
  - Request accepted in cycle N.
  - arvalid in N+1, handshake completes in N+1.
  - rready in N+2, beat taken in N+2.
  - rx_data_valid in N+3.
- Data is returned full-width and unshifted. The fetch stage selects the 32-bit half using its own addr[2].
- rx_r_valid_i while busy is ignored; it is not queued.
- No flush input. A redirected fetch consumes and discards the stale word itself, which keeps the bridge AXI-clean: no orphaned R beats.
- Reset mid-operation (any state) → IDLE with the reset values above. The memory side shares rst, so in-flight beats are abandoned.
- rx_data_ready while not in HOLD: no effect.

Decomposition:
- Shared package `ifu_axi_pkg`:
  - state enum (IDLE/ADDR/DATA/HOLD);
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, ARLEN_SINGLE = 8'd0;
  - a function mapping the byte mask to arsize.
- One sub-module is natural: `axi_size_encode`, combinational popcount → arsize, reusable by the LSU bridge.

Test Plan:
- Zero-wait read:
  - Stimulus: rx_r_addr_i = 64'h8000_0004, size 8'h0F; memory returns rdata = 64'h0000_0013_0000_0093.
  - Required: araddr = 64'h8000_0000, arsize = 2, arlen = 0; rx_data_valid at N+3 with that data; rx_resp_err = 0.
- Backpressure on both channels:
  - Stimulus: arready low for 3 cycles; rvalid delayed 5 cycles; rx_data_ready low for 4 cycles in HOLD.
  - Required: arvalid/araddr stable throughout; data held stable; exactly one AR and one R handshake.
- Error response:
  - Stimulus: rresp = 2'b10.
  - Required: rx_data_valid with rx_resp_err = 1; the next transaction with OKAY returns rx_resp_err = 0.
- Request while busy:
  - Stimulus: rx_r_valid_i held high through ADDR/DATA/HOLD.
  - Required: rx_r_ready_o = 0 throughout; exactly one AR issued; the second request is accepted only after IDLE is re-entered.
- Reset mid-transaction:
  - Stimulus: assert rst in ADDR with arvalid = 1, and again in HOLD.
  - Required: next cycle arvalid = 0, rx_data_valid = 0, rx_r_ready_o = 1; a subsequent request to 64'h8000_0008 completes normally.
- Size mapping:
  - Stimulus: masks 8'h01, 8'h03, 8'hFF, 8'h05.
  - Required: arsize = 0, 1, 3, 1 respectively.

Source files
------------

// File: rtl/ifu_axi_pkg.sv
// Shared definitions for the fetch/load-store AXI read bridges.
// Holds the state encoding, the AXI constants and the byte-mask to AxSIZE mapping.
package ifu_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD
    } state_e;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;

    // Bytes enabled -> log2 transfer size; irregular masks fall back to a full 8-byte beat.
    function automatic logic [2:0] mask_to_arsize(input logic [7:0] mask);
        logic [3:0] ones;
        ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + {3'b000, mask[i]};
        end
        case (ones)
            4'd1:    return 3'd0;
            4'd2:    return 3'd1;
            4'd4:    return 3'd2;
            4'd8:    return 3'd3;
            default: return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/ifu_axi_read_bridge_if.sv
// AXI4 read-channel bundle (AR + R) between a read bridge and instruction memory.
// master = bridge side, slave = memory/crossbar side.
interface ifu_axi_read_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_size_encode.sv
// Combinational byte-enable mask to AXI AxSIZE encoder.
// Shared between the fetch and load/store read bridges.
module axi_size_encode
    import ifu_axi_pkg::*;
(
    input  logic [7:0] byte_mask,
    output logic [2:0] arsize
);

    assign arsize = mask_to_arsize(byte_mask);

endmodule

// File: rtl/ifu_axi_read_bridge.sv
// Single-outstanding fetch-to-AXI4 read bridge: one request, one single-beat AR/R
// transaction, and the returned 64-bit word held until the fetch stage takes it.
module ifu_axi_read_bridge
    import ifu_axi_pkg::*;
#(
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64,
    parameter logic [3:0] ID     = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  rx_r_valid_i,
    output logic                  rx_r_ready_o,
    input  logic [ADDR_W-1:0]     rx_r_addr_i,
    input  logic [7:0]            rx_r_size_i,
    output logic [DATA_W-1:0]     rx_data_read_o,
    output logic                  rx_data_valid,
    input  logic                  rx_data_ready,
    output logic                  rx_resp_err,

    ifu_axi_read_bridge_if.master axi
);

    state_e     state;
    logic [2:0] req_arsize;

    axi_size_encode u_size_encode (
        .byte_mask (rx_r_size_i),
        .arsize    (req_arsize)
    );

    assign axi.arid    = ID;
    assign axi.arlen   = ARLEN_SINGLE;
    assign axi.arburst = BURST_INCR;

    // Byte offset is dropped (word is returned unshifted) and RLAST is not needed
    // because every transaction is exactly one beat.
    logic unused_inputs;
    assign unused_inputs = ^{rx_r_addr_i[2:0], axi.rlast};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rx_r_ready_o   <= 1'b1;
            rx_data_valid  <= 1'b0;
            rx_resp_err    <= 1'b0;
            rx_data_read_o <= '0;
            axi.arvalid    <= 1'b0;
            axi.araddr     <= '0;
            axi.arsize     <= '0;
            axi.rready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_r_valid_i) begin
                        axi.araddr   <= {rx_r_addr_i[ADDR_W-1:3], 3'b000};
                        axi.arsize   <= req_arsize;
                        axi.arvalid  <= 1'b1;
                        rx_r_ready_o <= 1'b0;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (axi.rvalid) begin
                        axi.rready     <= 1'b0;
                        rx_data_read_o <= axi.rdata;
                        rx_resp_err    <= (axi.rresp != RESP_OKAY);
                        rx_data_valid  <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    // Ready returns together with valid dropping, leaving a one-cycle gap.
                    if (rx_data_ready) begin
                        rx_data_valid <= 1'b0;
                        rx_resp_err   <= 1'b0;
                        rx_r_ready_o  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_axi_read_bridge.sv
// Directed self-checking bench for ifu_axi_read_bridge.
// The bench plays both the fetch stage and the instruction memory.
module tb_ifu_axi_read_bridge;

    logic        clk;
    logic        rst;
    logic        rx_r_valid_i;
    logic        rx_r_ready_o;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic [63:0] rx_data_read_o;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic        rx_resp_err;

    ifu_axi_read_bridge_if #(.ADDR_W(64), .DATA_W(64)) axi_bus ();

    ifu_axi_read_bridge #(.ADDR_W(64), .DATA_W(64), .ID(4'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_r_valid_i   (rx_r_valid_i),
        .rx_r_ready_o   (rx_r_ready_o),
        .rx_r_addr_i    (rx_r_addr_i),
        .rx_r_size_i    (rx_r_size_i),
        .rx_data_read_o (rx_data_read_o),
        .rx_data_valid  (rx_data_valid),
        .rx_data_ready  (rx_data_ready),
        .rx_resp_err    (rx_resp_err),
        .axi            (axi_bus.master)
    );

    int errors = 0;
    int checks = 0;
    int ar_cnt = 0;
    int r_cnt  = 0;
    int ar_base;
    int r_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && axi_bus.arvalid && axi_bus.arready) ar_cnt++;
        if (!rst && axi_bus.rvalid && axi_bus.rready) r_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with no wait states on either AXI channel or the fetch side.
    task automatic zero_wait_txn(input string tag, input logic [63:0] addr, input logic [7:0] size,
                                 input logic [63:0] data, input logic [1:0] resp,
                                 input logic [63:0] exp_addr, input logic [2:0] exp_size,
                                 input logic exp_err);
        rx_r_valid_i  = 1'b1;
        rx_r_addr_i   = addr;
        rx_r_size_i   = size;
        axi_bus.arready = 1'b1;
        tick();
        rx_r_valid_i = 1'b0;
        check_eq({tag, ".arvalid"}, 64'(axi_bus.arvalid), 64'd1);
        check_eq({tag, ".araddr"}, axi_bus.araddr, exp_addr);
        check_eq({tag, ".arsize"}, 64'(axi_bus.arsize), 64'(exp_size));
        check_eq({tag, ".arlen"}, 64'(axi_bus.arlen), 64'd0);
        check_eq({tag, ".req_ready"}, 64'(rx_r_ready_o), 64'd0);
        axi_bus.rdata  = data;
        axi_bus.rresp  = resp;
        axi_bus.rvalid = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        check_eq({tag, ".arvalid_drop"}, 64'(axi_bus.arvalid), 64'd0);
        check_eq({tag, ".rready"}, 64'(axi_bus.rready), 64'd1);
        check_eq({tag, ".early_valid"}, 64'(rx_data_valid), 64'd0);
        tick();
        axi_bus.rvalid = 1'b0;
        check_eq({tag, ".data_valid"}, 64'(rx_data_valid), 64'd1);
        check_eq({tag, ".data"}, rx_data_read_o, data);
        check_eq({tag, ".err"}, 64'(rx_resp_err), 64'(exp_err));
        check_eq({tag, ".rready_drop"}, 64'(axi_bus.rready), 64'd0);
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, 64'(rx_data_valid), 64'd0);
        check_eq({tag, ".ready_back"}, 64'(rx_r_ready_o), 64'd1);
    endtask

    initial begin
        rst             = 1'b1;
        rx_r_valid_i    = 1'b0;
        rx_r_addr_i     = '0;
        rx_r_size_i     = '0;
        rx_data_ready   = 1'b0;
        axi_bus.arready = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rlast   = 1'b1;
        axi_bus.rvalid  = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst.req_ready", 64'(rx_r_ready_o), 64'd1);
        check_eq("rst.data_valid", 64'(rx_data_valid), 64'd0);
        check_eq("rst.err", 64'(rx_resp_err), 64'd0);
        check_eq("rst.data", rx_data_read_o, 64'd0);
        check_eq("rst.arvalid", 64'(axi_bus.arvalid), 64'd0);
        check_eq("rst.araddr", axi_bus.araddr, 64'd0);
        check_eq("rst.arsize", 64'(axi_bus.arsize), 64'd0);
        check_eq("rst.rready", 64'(axi_bus.rready), 64'd0);
        check_eq("rst.arid", 64'(axi_bus.arid), 64'd0);
        check_eq("rst.arburst", 64'(axi_bus.arburst), 64'd1);
        rst = 1'b0;
        tick();

        // Zero-wait read
        zero_wait_txn("zw", 64'h8000_0004, 8'h0F, 64'h0000_0013_0000_0093, 2'b00,
                      64'h8000_0000, 3'd2, 1'b0);

        // Backpressure on AR, R and the fetch side
        ar_base = ar_cnt;
        r_base  = r_cnt;
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h1234_5678_9ABC_DEF7;
        rx_r_size_i  = 8'h03;
        tick();
        rx_r_valid_i = 1'b0;
        rx_r_addr_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp.arvalid_hold", 64'(axi_bus.arvalid), 64'd1);
            check_eq("bp.araddr_hold", axi_bus.araddr, 64'h1234_5678_9ABC_DEF0);
            check_eq("bp.arsize_hold", 64'(axi_bus.arsize), 64'd1);
            tick();
        end
        check_eq("bp.arvalid_last", 64'(axi_bus.arvalid), 64'd1);
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.rready_wait", 64'(axi_bus.rready), 64'd1);
            check_eq("bp.valid_wait", 64'(rx_data_valid), 64'd0);
            tick();
        end
        axi_bus.rdata  = 64'hDEAD_BEEF_CAFE_F00D;
        axi_bus.rresp  = 2'b00;
        axi_bus.rvalid = 1'b1;
        tick();
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata  = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp.hold_valid", 64'(rx_data_valid), 64'd1);
            check_eq("bp.hold_data", rx_data_read_o, 64'hDEAD_BEEF_CAFE_F00D);
            check_eq("bp.hold_req_ready", 64'(rx_r_ready_o), 64'd0);
            tick();
        end
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check_eq("bp.valid_drop", 64'(rx_data_valid), 64'd0);
        check_eq("bp.ar_count", 64'(ar_cnt - ar_base), 64'd1);
        check_eq("bp.r_count", 64'(r_cnt - r_base), 64'd1);

        // Error response, then an OKAY transaction clears the flag
        zero_wait_txn("err", 64'h0000_0000_0000_0100, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10,
                      64'h0000_0000_0000_0100, 3'd3, 1'b1);
        zero_wait_txn("ok", 64'h0000_0000_0000_0108, 8'hFF, 64'h0123_4567_89AB_CDEF, 2'b00,
                      64'h0000_0000_0000_0108, 3'd3, 1'b0);

        // Request held high while busy
        ar_base = ar_cnt;
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h0000_0000_0000_0200;
        rx_r_size_i  = 8'h0F;
        tick();
        check_eq("busy.addr_ready", 64'(rx_r_ready_o), 64'd0);
        tick();
        check_eq("busy.addr_ready2", 64'(rx_r_ready_o), 64'd0);
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        check_eq("busy.data_ready", 64'(rx_r_ready_o), 64'd0);
        axi_bus.rdata  = 64'h0000_0000_0000_0BEE;
        axi_bus.rvalid = 1'b1;
        tick();
        axi_bus.rvalid = 1'b0;
        check_eq("busy.hold_ready", 64'(rx_r_ready_o), 64'd0);
        tick();
        check_eq("busy.hold_ready2", 64'(rx_r_ready_o), 64'd0);
        check_eq("busy.one_ar", 64'(ar_cnt - ar_base), 64'd1);
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check_eq("busy.idle_ready", 64'(rx_r_ready_o), 64'd1);
        check_eq("busy.idle_arvalid", 64'(axi_bus.arvalid), 64'd0);
        rx_r_addr_i = 64'h0000_0000_0000_0300;
        tick();
        rx_r_valid_i = 1'b0;
        check_eq("busy.second_arvalid", 64'(axi_bus.arvalid), 64'd1);
        check_eq("busy.second_araddr", axi_bus.araddr, 64'h0000_0000_0000_0300);
        axi_bus.arready = 1'b1;
        tick();
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b1;
        tick();
        axi_bus.rvalid  = 1'b0;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        check_eq("busy.two_ar", 64'(ar_cnt - ar_base), 64'd2);

        // Reset while in ADDR
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h0000_0000_0000_0400;
        rx_r_size_i  = 8'h0F;
        tick();
        rx_r_valid_i = 1'b0;
        check_eq("rsta.pre_arvalid", 64'(axi_bus.arvalid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rsta.arvalid", 64'(axi_bus.arvalid), 64'd0);
        check_eq("rsta.data_valid", 64'(rx_data_valid), 64'd0);
        check_eq("rsta.req_ready", 64'(rx_r_ready_o), 64'd1);
        zero_wait_txn("rsta_next", 64'h8000_0008, 8'h0F, 64'h7777_0000_0000_8888, 2'b00,
                      64'h8000_0008, 3'd2, 1'b0);

        // Reset while in HOLD
        rx_r_valid_i = 1'b1;
        rx_r_addr_i  = 64'h0000_0000_0000_0500;
        axi_bus.arready = 1'b1;
        tick();
        rx_r_valid_i = 1'b0;
        tick();
        axi_bus.arready = 1'b0;
        axi_bus.rdata  = 64'h5555_6666_7777_8888;
        axi_bus.rvalid = 1'b1;
        tick();
        axi_bus.rvalid = 1'b0;
        check_eq("rsth.pre_valid", 64'(rx_data_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rsth.data_valid", 64'(rx_data_valid), 64'd0);
        check_eq("rsth.arvalid", 64'(axi_bus.arvalid), 64'd0);
        check_eq("rsth.req_ready", 64'(rx_r_ready_o), 64'd1);
        check_eq("rsth.data", rx_data_read_o, 64'd0);
        zero_wait_txn("rsth_next", 64'h8000_0008, 8'h0F, 64'h0000_0000_CAFE_BABE, 2'b00,
                      64'h8000_0008, 3'd2, 1'b0);

        // Byte-mask to arsize mapping
        zero_wait_txn("sz01", 64'h0000_0000_0000_1001, 8'h01, 64'h0000_0000_0000_0001, 2'b00,
                      64'h0000_0000_0000_1000, 3'd0, 1'b0);
        zero_wait_txn("sz03", 64'h0000_0000_0000_1012, 8'h03, 64'h0000_0000_0000_0002, 2'b00,
                      64'h0000_0000_0000_1010, 3'd1, 1'b0);
        zero_wait_txn("szFF", 64'h0000_0000_0000_1020, 8'hFF, 64'h0000_0000_0000_0003, 2'b00,
                      64'h0000_0000_0000_1020, 3'd3, 1'b0);
        zero_wait_txn("sz05", 64'h0000_0000_0000_103C, 8'h05, 64'h0000_0000_0000_0004, 2'b01,
                      64'h0000_0000_0000_1038, 3'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
